// File: rtl/sa_result_drain.sv
// Result drain for the 4x4 systolic array: captures C0..C3 on a done edge and
// streams the 16 words row-major over valid/ready. Optional SA_DRAIN_ACCUM_EN adds tile accumulation.
module sa_result_drain #(
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128
) (
  input  logic                  clk,
  input  logic                  sa_rst_n,
`ifdef SA_DRAIN_ACCUM_EN
  input  logic                  tile_first_i,
  input  logic                  tile_last_i,
`endif
  input  logic                  sa_done,
  input  logic [DATAC_BITS-1:0] local_buffer_C0,
  input  logic [DATAC_BITS-1:0] local_buffer_C1,
  input  logic [DATAC_BITS-1:0] local_buffer_C2,
  input  logic [DATAC_BITS-1:0] local_buffer_C3,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_BITS-1:0]  out_data_o,
  output logic [3:0]            out_idx_o,
  output logic                  out_last_o,
  output logic                  drain_busy_o,
  output logic                  overrun_o
);

  localparam int N_ROWS  = 4;
  localparam int N_WORDS = 16;

  if (DATAC_BITS != N_ROWS * DATA_BITS) begin : g_bad_cfg
    $error("sa_result_drain: DATAC_BITS must equal 4*DATA_BITS");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRAIN = 2'b01
  } state_e;

  state_e               state_q, state_d;
  logic                 done_prev_q, done_prev_d;
  logic [DATA_BITS-1:0] word_q [N_WORDS];
  logic [DATA_BITS-1:0] word_d [N_WORDS];
  logic [3:0]           idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic                 overrun_q, overrun_d;

  logic [DATAC_BITS-1:0] c_row  [N_ROWS];
  logic [DATA_BITS-1:0]  c_word [N_WORDS];
  logic                  done_edge;
  logic                  handshake;
  logic [3:0]            next_idx;

  assign c_row[0] = local_buffer_C0;
  assign c_row[1] = local_buffer_C1;
  assign c_row[2] = local_buffer_C2;
  assign c_row[3] = local_buffer_C3;

  // Column 0 sits in the MSBs of each row.
  always_comb begin
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_ROWS; c++) begin
        c_word[r*N_ROWS + c] = c_row[r][DATAC_BITS-1-c*DATA_BITS -: DATA_BITS];
      end
    end
  end

  assign done_edge = sa_done && !done_prev_q;
  assign handshake = valid_q && out_ready_i;
  assign next_idx  = idx_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    done_prev_d = sa_done;
    word_d      = word_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    data_d      = data_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (done_edge) begin
          for (int k = 0; k < N_WORDS; k++) begin
`ifdef SA_DRAIN_ACCUM_EN
            word_d[k] = (tile_first_i ? '0 : word_q[k]) + c_word[k];
`else
            word_d[k] = c_word[k];
`endif
          end
`ifdef SA_DRAIN_ACCUM_EN
          if (tile_last_i) begin
            state_d = S_DRAIN;
            idx_d   = 4'd0;
            valid_d = 1'b1;
            data_d  = word_d[0];
          end
`else
          state_d = S_DRAIN;
          idx_d   = 4'd0;
          valid_d = 1'b1;
          data_d  = word_d[0];
`endif
        end
      end
      S_DRAIN: begin
        // The array must not be restarted while draining; a new tile here is lost.
        if (done_edge) overrun_d = 1'b1;
        if (handshake) begin
          if (idx_q == 4'd15) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d  = next_idx;
            data_d = word_q[next_idx];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    last_d = valid_d && (idx_d == 4'd15);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!sa_rst_n) begin
      state_q     <= S_IDLE;
      done_prev_q <= 1'b0;
      idx_q       <= 4'd0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the capture file is reset because accumulation and reset-state
      // visibility depend on it; a pure buffer would normally skip this.
      for (int k = 0; k < N_WORDS; k++) word_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= done_prev_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
      overrun_q   <= overrun_d;
      for (int k = 0; k < N_WORDS; k++) word_q[k] <= word_d[k];
    end
  end

  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign out_idx_o    = idx_q;
  assign out_last_o   = last_q;
  assign drain_busy_o = (state_q == S_DRAIN);
  assign overrun_o    = overrun_q;

endmodule
